// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath widths, memory-stage FSM encoding and
// control-flow helpers used by the memory stage.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // IDLE: ready for the next instruction; WAIT: data access outstanding;
    // HALTED: a halt has retired and the core stays frozen until reset.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } memstate_t;

    // beq is taken on zero, bne on non-zero.
    function automatic logic branch_taken(input logic branch, input logic zero,
                                          input logic bne);
        return branch & (zero ^ bne);
    endfunction

    // Redirect target with priority jr > jump > branch.
    function automatic word_t redirect_target(input logic jr, input logic jump,
                                              input word_t rdat1, input word_t jumpaddr,
                                              input word_t branchaddr);
        if (jr)        return rdat1;
        else if (jump) return jumpaddr;
        else           return branchaddr;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-cache request port between the memory stage (master) and the
// data cache (slave).
interface memory_stage_if;
    import cpu_types_pkg::*;

    logic  dREN;
    logic  dWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;

    modport master (
        output dREN, dWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dREN, dWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );

endinterface

// File: rtl/memory_stage_link_register.sv
// Load-linked reservation: one valid bit plus the linked address. Set by a
// retiring ll, cleared by any retiring store/sc or a snoop invalidation of
// the linked address.
module link_register
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  set,
    input  word_t set_addr,
    input  logic  clear,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    input  word_t match_addr,
    output logic  match
);

    logic  valid_q, valid_d;
    word_t addr_q, addr_d;

    // Next reservation: snoop/clear drop it, a new ll takes precedence.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        valid_d = valid_q;
        addr_d  = addr_q;
        if (snoop_inv && valid_q && (snoop_addr == addr_q)) valid_d = 1'b0;
        if (clear)                                          valid_d = 1'b0;
        if (set) begin
            valid_d = 1'b1;
            addr_d  = set_addr;
        end
    end

    // Reservation register; invalid out of reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all flops sample together.
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign match = valid_q && (match_addr == addr_q);

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the five-stage MIPS pipeline: issues data-cache requests,
// stalls upstream while an access is outstanding, resolves branches/jumps and
// fills the MEM/WB latch. Optional feature macro: LLSC_EN (ll/sc support).
module memory_stage
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     regwrite_i,
    input  logic     memtoreg_i,
    input  logic     memread_i,
    input  logic     memwrite_i,
    input  logic     halt_i,
    input  logic     jump_i,
    input  logic     jr_i,
    input  logic     branch_i,
    input  logic     bne_i,
    input  logic     zero_i,
    input  word_t    aluoutput_i,
    input  word_t    rdat1_i,
    input  word_t    rdat2_i,
    input  word_t    jumpaddr_i,
    input  word_t    branchaddr_i,
    input  regbits_t rd_i,
`ifdef LLSC_EN
    input  logic     ll_i,
    input  logic     sc_i,
    input  logic     snoopinv_i,
    input  word_t    snoopaddr_i,
`endif
    memory_stage_if.master dcif,
    output logic     pcpause,
    output logic     nopmode,
    output logic     pcsel,
    output word_t    pcnext,
    output logic     wb_regwrite,
    output logic     wb_memtoreg,
    output logic     wb_halt,
    output regbits_t wb_rd,
    output word_t    wb_aluout,
    output word_t    wb_memload
);

    memstate_t state_q, state_d;

    logic     wb_regwrite_q, wb_regwrite_d;
    logic     wb_memtoreg_q, wb_memtoreg_d;
    logic     wb_halt_q, wb_halt_d;
    regbits_t wb_rd_q, wb_rd_d;
    word_t    wb_aluout_q, wb_aluout_d;
    word_t    wb_memload_q, wb_memload_d;

    logic     complete;
    logic     sc_fail;
    logic     store_en;
    logic     mem_req;
    word_t    retire_aluout;
    logic     dren, dwen;
    word_t    dmemaddr, dmemstore;

`ifdef LLSC_EN
    logic link_match;
    logic link_set;
    logic link_clear;

    // A failed sc is dropped before it reaches the cache and reports 0.
    assign sc_fail       = sc_i & memwrite_i & ~link_match;
    assign retire_aluout = sc_i ? {{(WORD_W-1){1'b0}}, ~sc_fail} : aluoutput_i;
    assign link_set      = complete & ll_i & memread_i;
    assign link_clear    = complete & (memwrite_i | sc_i);

    link_register u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (link_set),
        .set_addr   (aluoutput_i),
        .clear      (link_clear),
        .snoop_inv  (snoopinv_i),
        .snoop_addr (snoopaddr_i),
        .match_addr (aluoutput_i),
        .match      (link_match)
    );
`else
    assign sc_fail       = 1'b0;
    assign retire_aluout = aluoutput_i;
`endif

    assign store_en = memwrite_i & ~sc_fail;
    assign mem_req  = memread_i | store_en;

    // Request/stall/redirect decode and MEM/WB next values; everything is
    // forced quiet while reset is held so a pending request drops at once.
    always_comb begin
        state_d       = state_q;
        dren          = 1'b0;
        dwen          = 1'b0;
        dmemaddr      = '0;
        dmemstore     = '0;
        pcpause       = 1'b0;
        pcsel         = 1'b0;
        nopmode       = 1'b0;
        pcnext        = '0;
        complete      = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_halt_d     = 1'b0;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_rd_d       = wb_rd_q;
        wb_aluout_d   = wb_aluout_q;
        wb_memload_d  = wb_memload_q;

        if (nRST) begin
            unique case (state_q)
                // IDLE and WAIT share one path: the request is presented
                // until dhit, since the EX/MEM latch is frozen by pcpause.
                IDLE, WAIT: begin
                    if (mem_req) begin
                        dren      = memread_i;
                        dwen      = store_en;
                        dmemaddr  = aluoutput_i;
                        dmemstore = rdat2_i;
                        if (dcif.dhit) begin
                            complete = 1'b1;
                        end else begin
                            pcpause = 1'b1;
                            state_d = WAIT;
                        end
                    end else begin
                        complete = 1'b1;
                    end
                end
                HALTED: begin
                    pcpause   = 1'b1;
                    wb_halt_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase

            if (complete) begin
                pcsel         = jump_i | jr_i | branch_taken(branch_i, zero_i, bne_i);
                nopmode       = pcsel;
                pcnext        = redirect_target(jr_i, jump_i, rdat1_i, jumpaddr_i,
                                                branchaddr_i);
                wb_regwrite_d = regwrite_i;
                wb_memtoreg_d = memtoreg_i;
                wb_halt_d     = halt_i;
                wb_rd_d       = rd_i;
                wb_aluout_d   = retire_aluout;
                if (memread_i) wb_memload_d = dcif.dmemload;
                state_d       = halt_i ? HALTED : IDLE;
            end
        end
    end

    // FSM state and MEM/WB latch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_halt_q     <= 1'b0;
            wb_rd_q       <= '0;
            wb_aluout_q   <= '0;
            wb_memload_q  <= '0;
        end else begin
            state_q       <= state_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_halt_q     <= wb_halt_d;
            wb_rd_q       <= wb_rd_d;
            wb_aluout_q   <= wb_aluout_d;
            wb_memload_q  <= wb_memload_d;
        end
    end

    assign dcif.dREN      = dren;
    assign dcif.dWEN      = dwen;
    assign dcif.dmemaddr  = dmemaddr;
    assign dcif.dmemstore = dmemstore;

    assign wb_regwrite = wb_regwrite_q;
    assign wb_memtoreg = wb_memtoreg_q;
    assign wb_halt     = wb_halt_q;
    assign wb_rd       = wb_rd_q;
    assign wb_aluout   = wb_aluout_q;
    assign wb_memload  = wb_memload_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: inputs change on the falling edge,
// combinational outputs are checked 1 ns later, MEM/WB 1 ns after the
// rising edge. Covers the ll/sc path when LLSC_EN is defined.
module tb_memory_stage;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     nRST;
    logic     regwrite_i, memtoreg_i, memread_i, memwrite_i, halt_i;
    logic     jump_i, jr_i, branch_i, bne_i, zero_i;
    word_t    aluoutput_i, rdat1_i, rdat2_i, jumpaddr_i, branchaddr_i;
    regbits_t rd_i;
`ifdef LLSC_EN
    logic     ll_i, sc_i, snoopinv_i;
    word_t    snoopaddr_i;
`endif
    logic     pcpause, nopmode, pcsel;
    word_t    pcnext;
    logic     wb_regwrite, wb_memtoreg, wb_halt;
    regbits_t wb_rd;
    word_t    wb_aluout, wb_memload;

    int checks = 0;
    int errors = 0;

    memory_stage_if dcif ();

    memory_stage dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .regwrite_i   (regwrite_i),
        .memtoreg_i   (memtoreg_i),
        .memread_i    (memread_i),
        .memwrite_i   (memwrite_i),
        .halt_i       (halt_i),
        .jump_i       (jump_i),
        .jr_i         (jr_i),
        .branch_i     (branch_i),
        .bne_i        (bne_i),
        .zero_i       (zero_i),
        .aluoutput_i  (aluoutput_i),
        .rdat1_i      (rdat1_i),
        .rdat2_i      (rdat2_i),
        .jumpaddr_i   (jumpaddr_i),
        .branchaddr_i (branchaddr_i),
        .rd_i         (rd_i),
`ifdef LLSC_EN
        .ll_i         (ll_i),
        .sc_i         (sc_i),
        .snoopinv_i   (snoopinv_i),
        .snoopaddr_i  (snoopaddr_i),
`endif
        .dcif         (dcif),
        .pcpause      (pcpause),
        .nopmode      (nopmode),
        .pcsel        (pcsel),
        .pcnext       (pcnext),
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg),
        .wb_halt      (wb_halt),
        .wb_rd        (wb_rd),
        .wb_aluout    (wb_aluout),
        .wb_memload   (wb_memload)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        regwrite_i = 0; memtoreg_i = 0; memread_i = 0; memwrite_i = 0; halt_i = 0;
        jump_i = 0; jr_i = 0; branch_i = 0; bne_i = 0; zero_i = 0;
        aluoutput_i = '0; rdat1_i = '0; rdat2_i = '0; jumpaddr_i = '0; branchaddr_i = '0;
        rd_i = '0;
        dcif.dhit = 0; dcif.dmemload = '0;
`ifdef LLSC_EN
        ll_i = 0; sc_i = 0; snoopinv_i = 0; snoopaddr_i = '0;
`endif
    endtask

    // Falling edge, then settle: the point where new inputs are applied.
    task automatic next_neg();
        @(negedge CLK);
    endtask

    // Rising edge plus 1 ns: MEM/WB sampling point.
    task automatic after_pos();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        clear_inputs();
        nRST = 1'b0;

        // Reset state
        #3;
        check("rst_dREN", dcif.dREN, 0);
        check("rst_pcpause", pcpause, 0);
        check("rst_pcsel", pcsel, 0);
        check("rst_wb_regwrite", wb_regwrite, 0);
        check("rst_wb_halt", wb_halt, 0);
        check("rst_wb_aluout", wb_aluout, 0);
        next_neg();
        nRST = 1'b1;

        // lw hit in the same cycle
        next_neg();
        memread_i = 1; regwrite_i = 1; memtoreg_i = 1; rd_i = 5'd5;
        aluoutput_i = 32'h0000_0040; dcif.dhit = 1; dcif.dmemload = 32'hDEAD_BEEF;
        #1;
        check("lw_dREN", dcif.dREN, 1);
        check("lw_dWEN", dcif.dWEN, 0);
        check("lw_addr", dcif.dmemaddr, 32'h40);
        check("lw_pcpause", pcpause, 0);
        after_pos();
        check("lw_wb_memload", wb_memload, 32'hDEAD_BEEF);
        check("lw_wb_regwrite", wb_regwrite, 1);
        check("lw_wb_memtoreg", wb_memtoreg, 1);
        check("lw_wb_rd", wb_rd, 5);
        check("lw_wb_aluout", wb_aluout, 32'h40);
        next_neg();
        clear_inputs();
        #1;
        check("lw_dREN_drop", dcif.dREN, 0);

        // dhit with no request is ignored
        next_neg();
        dcif.dhit = 1; dcif.dmemload = 32'h1111_2222;
        #1;
        check("idle_dhit_pcpause", pcpause, 0);
        after_pos();
        check("idle_dhit_memload", wb_memload, 32'hDEAD_BEEF);

        // sw, dhit arrives 3 cycles after the request
        next_neg();
        clear_inputs();
        memwrite_i = 1; rdat2_i = 32'h1234; aluoutput_i = 32'h80; dcif.dmemload = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("sw_stall%0d_dWEN", i), dcif.dWEN, 1);
            check($sformatf("sw_stall%0d_addr", i), dcif.dmemaddr, 32'h80);
            check($sformatf("sw_stall%0d_store", i), dcif.dmemstore, 32'h1234);
            check($sformatf("sw_stall%0d_pcpause", i), pcpause, 1);
            after_pos();
            check($sformatf("sw_stall%0d_bubble", i), wb_regwrite, 0);
            next_neg();
        end
        dcif.dhit = 1;
        #1;
        check("sw_hit_dWEN", dcif.dWEN, 1);
        check("sw_hit_addr", dcif.dmemaddr, 32'h80);
        check("sw_hit_pcpause", pcpause, 0);
        after_pos();
        check("sw_wb_aluout", wb_aluout, 32'h80);
        check("sw_wb_memload_held", wb_memload, 32'hDEAD_BEEF);

        // lw miss by one cycle: one bubble then the result
        next_neg();
        clear_inputs();
        memread_i = 1; regwrite_i = 1; rd_i = 5'd9; aluoutput_i = 32'hC0;
        dcif.dmemload = 32'hCAFE_F00D;
        after_pos();
        check("lwm_bubble", wb_regwrite, 0);
        next_neg();
        dcif.dhit = 1;
        after_pos();
        check("lwm_wb_regwrite", wb_regwrite, 1);
        check("lwm_wb_memload", wb_memload, 32'hCAFE_F00D);
        check("lwm_wb_rd", wb_rd, 9);

        // Branches and jumps (combinational redirect)
        next_neg();
        clear_inputs();
        branch_i = 1; zero_i = 1; branchaddr_i = 32'h100;
        #1;
        check("beq_pcsel", pcsel, 1);
        check("beq_pcnext", pcnext, 32'h100);
        check("beq_nopmode", nopmode, 1);
        bne_i = 1;
        #1;
        check("bne_eq_pcsel", pcsel, 0);
        check("bne_eq_nopmode", nopmode, 0);
        zero_i = 0;
        #1;
        check("bne_ne_pcsel", pcsel, 1);
        next_neg();
        clear_inputs();
        jr_i = 1; jump_i = 1; rdat1_i = 32'h200; jumpaddr_i = 32'h300; branchaddr_i = 32'h400;
        #1;
        check("jr_pcsel", pcsel, 1);
        check("jr_pcnext", pcnext, 32'h200);
        jr_i = 0;
        #1;
        check("j_pcnext", pcnext, 32'h300);

        // No redirect while stalled; it fires on the completing cycle
        next_neg();
        clear_inputs();
        memread_i = 1; aluoutput_i = 32'h44; branch_i = 1; zero_i = 1; branchaddr_i = 32'h180;
        #1;
        check("stall_pcpause", pcpause, 1);
        check("stall_pcsel", pcsel, 0);
        check("stall_nopmode", nopmode, 0);
        after_pos();
        next_neg();
        dcif.dhit = 1;
        #1;
        check("stallhit_pcsel", pcsel, 1);
        check("stallhit_pcnext", pcnext, 32'h180);
        after_pos();

        // Reset asserted mid-miss drops the request immediately
        next_neg();
        clear_inputs();
        memread_i = 1; regwrite_i = 1; aluoutput_i = 32'h48;
        after_pos();
        #2;
        check("rstmiss_dREN_before", dcif.dREN, 1);
        nRST = 1'b0;
        #1;
        check("rstmiss_dREN", dcif.dREN, 0);
        check("rstmiss_pcpause", pcpause, 0);
        check("rstmiss_wb_memload", wb_memload, 0);
        next_neg();
        clear_inputs();
        nRST = 1'b1;
        #1;
        check("rstmiss_idle_pcpause", pcpause, 0);

`ifdef LLSC_EN
        // ll then sc to the same address succeeds
        next_neg();
        clear_inputs();
        ll_i = 1; memread_i = 1; aluoutput_i = 32'h80; dcif.dhit = 1;
        after_pos();
        next_neg();
        clear_inputs();
        sc_i = 1; memwrite_i = 1; aluoutput_i = 32'h80; rdat2_i = 32'h7; dcif.dhit = 1;
        #1;
        check("sc_ok_dWEN", dcif.dWEN, 1);
        after_pos();
        check("sc_ok_wb_aluout", wb_aluout, 1);

        // ll, snoop invalidation of the linked address, then sc fails
        next_neg();
        clear_inputs();
        ll_i = 1; memread_i = 1; aluoutput_i = 32'h80; dcif.dhit = 1;
        after_pos();
        next_neg();
        clear_inputs();
        snoopinv_i = 1; snoopaddr_i = 32'h80;
        after_pos();
        next_neg();
        clear_inputs();
        sc_i = 1; memwrite_i = 1; aluoutput_i = 32'h80; rdat2_i = 32'h7;
        #1;
        check("sc_fail_dWEN", dcif.dWEN, 0);
        check("sc_fail_pcpause", pcpause, 0);
        after_pos();
        check("sc_fail_wb_aluout", wb_aluout, 0);
`endif

        // Store together with halt: store completes first, then HALTED
        next_neg();
        clear_inputs();
        memwrite_i = 1; halt_i = 1; aluoutput_i = 32'h90; rdat2_i = 32'hABCD;
        #1;
        check("halt_sw_dWEN", dcif.dWEN, 1);
        after_pos();
        check("halt_sw_wb_halt_bubble", wb_halt, 0);
        next_neg();
        dcif.dhit = 1;
        after_pos();
        check("halt_wb_halt", wb_halt, 1);
        check("halt_pcpause", pcpause, 1);
        next_neg();
        clear_inputs();
        memread_i = 1; regwrite_i = 1; aluoutput_i = 32'h50; dcif.dhit = 1;
        #1;
        check("halted_dREN", dcif.dREN, 0);
        check("halted_dWEN", dcif.dWEN, 0);
        check("halted_pcpause", pcpause, 1);
        after_pos();
        check("halted_wb_halt", wb_halt, 1);
        check("halted_wb_regwrite", wb_regwrite, 0);
        after_pos();
        check("halted_wb_halt_sticky", wb_halt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
